// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with branch redirect, one-bubble squash
// and a one-entry hold buffer for downstream stalls.
module fetch_unit #(
   parameter int PC_W     = 11,
   parameter int INSTR_W  = 32,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_control,
   input  logic [PC_W-1:0]    branch_pc,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   output logic [PC_W-1:0]    link_pc,
   output logic [CNT_W-1:0]   redirect_cnt
);
   typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIRECT} state_t;
   state_t state, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pend_pc, pend_d;
   logic [INSTR_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cnt_d;
   logic advance;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         pc_q         <= PC_W'(RESET_PC);
         pend_pc      <= '0;
         hold_q       <= '0;
         redirect_cnt <= '0;
      end else begin
         state        <= state_d;
         pc_q         <= pc_d;
         pend_pc      <= pend_d;
         hold_q       <= hold_d;
         redirect_cnt <= cnt_d;
      end
   end
   // BOOT and REDIRECT always advance; a valid slot advances unless redirected or stalled
   always_comb begin
      state_d = state;
      pc_d    = pc_q;
      pend_d  = pend_pc;
      hold_d  = hold_q;
      cnt_d   = redirect_cnt;
      advance = !instr_valid || (!branch_control && !stall);
      if (advance) begin
         pend_d  = pc_q;
         pc_d    = pc_q + PC_W'(1);
         state_d = RUN;
      end else if (branch_control) begin
         pc_d    = branch_pc;
         cnt_d   = &redirect_cnt ? redirect_cnt : redirect_cnt + CNT_W'(1);
         state_d = REDIRECT;
      end else begin
         hold_d  = (state == RUN) ? imem_rdata : hold_q;
         state_d = HOLD;
      end
   end
   assign imem_addr   = pc_q;
   assign instr_valid = (state == RUN) || (state == HOLD);
   assign instr       = (state == RUN) ? imem_rdata : (state == HOLD) ? hold_q : '0;
   assign instr_pc    = instr_valid ? pend_pc : '0;
   assign link_pc     = instr_pc + PC_W'(1);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit against a synchronous ROM mem[a]=0x1000+a.
module tb_fetch_unit;
   logic        clk = 0, rst_n = 0, stall = 0, branch_control = 0;
   logic [10:0] branch_pc = 0, imem_addr, instr_pc, link_pc;
   logic [31:0] imem_rdata = 0, instr;
   logic        instr_valid;
   logic [15:0] redirect_cnt;
   int checks = 0, errors = 0;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_control(branch_control),
      .branch_pc(branch_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .link_pc(link_pc), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= 32'h1000 + 32'(imem_addr);

   typedef struct {
      logic        s, b;
      logic [10:0] bpc;
      logic        v;
      logic [10:0] pc;
      logic [31:0] ins;
      logic [15:0] cnt;
      logic [10:0] addr;
   } vec_t;
   vec_t vt[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic b, input logic [10:0] bpc);
      stall = s; branch_control = b; branch_pc = bpc;
      @(posedge clk); #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [10:0] pc,
                          input logic [31:0] ins, input logic [15:0] cnt);
      chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
      chk({tag, ".cnt"}, 32'(redirect_cnt), 32'(cnt));
      if (v) begin
         chk({tag, ".pc"}, 32'(instr_pc), 32'(pc));
         chk({tag, ".instr"}, instr, ins);
         chk({tag, ".link"}, 32'(link_pc), 32'(11'(pc + 11'd1)));
      end
   endtask

   initial begin
      //        s  b  bpc    v  pc    instr       cnt addr
      vt[0]  = '{0, 0, 0,    1, 0,    32'h1000,   0,  1};
      vt[1]  = '{0, 0, 0,    1, 1,    32'h1001,   0,  2};
      vt[2]  = '{0, 0, 0,    1, 2,    32'h1002,   0,  3};
      vt[3]  = '{0, 0, 0,    1, 3,    32'h1003,   0,  4};
      vt[4]  = '{0, 1, 235,  0, 0,    0,          1,  235};
      vt[5]  = '{0, 0, 0,    1, 235,  32'h10EB,   1,  236};
      vt[6]  = '{0, 1, 5,    0, 0,    0,          2,  5};
      vt[7]  = '{0, 0, 0,    1, 5,    32'h1005,   2,  6};
      vt[8]  = '{1, 0, 0,    1, 5,    32'h1005,   2,  6};
      vt[9]  = '{1, 0, 0,    1, 5,    32'h1005,   2,  6};
      vt[10] = '{1, 0, 0,    1, 5,    32'h1005,   2,  6};
      vt[11] = '{0, 0, 0,    1, 6,    32'h1006,   2,  7};
      vt[12] = '{0, 0, 0,    1, 7,    32'h1007,   2,  8};
      vt[13] = '{1, 0, 0,    1, 7,    32'h1007,   2,  8};
      vt[14] = '{1, 1, 2046, 0, 0,    0,          3,  2046};
      vt[15] = '{1, 1, 100,  1, 2046, 32'h17FE,   3,  2047};
      vt[16] = '{0, 0, 0,    1, 2047, 32'h17FF,   3,  0};
      vt[17] = '{0, 0, 0,    1, 0,    32'h1000,   3,  1};
      vt[18] = '{0, 0, 0,    1, 1,    32'h1001,   3,  2};

      #1;
      chk("rst.valid", 32'(instr_valid), 0);
      chk("rst.instr", instr, 0);
      chk("rst.pc", 32'(instr_pc), 0);
      chk("rst.addr", 32'(imem_addr), 0);
      chk("rst.cnt", 32'(redirect_cnt), 0);
      @(posedge clk); #1;
      rst_n = 1;
      chk("boot.valid", 32'(instr_valid), 0);
      chk("boot.addr", 32'(imem_addr), 0);

      for (int i = 0; i < 19; i++) begin
         step(vt[i].s, vt[i].b, vt[i].bpc);
         chk_out($sformatf("v%0d", i), vt[i].v, vt[i].pc, vt[i].ins, vt[i].cnt);
         chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vt[i].addr));
      end

      step(1, 0, 0);
      chk_out("hold_pre_rst", 1, 1, 32'h1001, 3);
      #2 rst_n = 0;
      #1;
      chk_out("mid_rst", 0, 0, 0, 0);
      chk("mid_rst.instr", instr, 0);
      chk("mid_rst.pc", 32'(instr_pc), 0);
      chk("mid_rst.addr", 32'(imem_addr), 0);
      @(negedge clk);
      rst_n = 1;
      stall = 0;
      #1;
      chk("post_rst.valid", 32'(instr_valid), 0);
      step(0, 0, 0);
      chk_out("restart0", 1, 0, 32'h1000, 0);
      step(0, 0, 0);
      chk_out("restart1", 1, 1, 32'h1001, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
